cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor of the fixed 16-bit ripple-of-4-bit-CLA adder.
- Operand width is generic. Lookahead groups of GROUP bits are chained inside each pipeline stage, and GROUPS_PER_STAGE groups are resolved per stage.
- Valid/ready handshake on both sides with full backpressure. Throughput is one operation per cycle.
- Used as the ALU add path in the datapath, where a single-cycle 32-bit carry chain misses timing.

---
 rtl/cla_pipe_adder.sv | 135 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves GROUP*GROUPS_PER_STAGE result bits and hands its carry to the next.
module cla_pipe_adder #(
  parameter int WIDTH            = 32,
  parameter int GROUP            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S  = GROUP * GROUPS_PER_STAGE;
  localparam int NS = WIDTH / S;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  // One stage slice: returns {carry_out, sum[S-1:0]}.
  function automatic logic [S:0] cla_slice(input logic [S-1:0] x,
                                           input logic [S-1:0] y,
                                           input logic         c_in);
    logic [S-1:0]                g, p, s;
    logic [GROUPS_PER_STAGE:0]   gc;
    logic                        gg, gp, c, t;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc    = '0;
    gc[0] = c_in;
    for (int grp = 0; grp < GROUPS_PER_STAGE; grp++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        // carry into bit i written as a flat sum of products over the group
        c = gc[grp];
        for (int j = 0; j < i; j++) c = c & p[grp*GROUP+j];
        for (int j = 0; j < i; j++) begin
          t = g[grp*GROUP+j];
          for (int m = j + 1; m < i; m++) t = t & p[grp*GROUP+m];
          c = c | t;
        end
        s[grp*GROUP+i] = p[grp*GROUP+i] ^ c;
        gg = g[grp*GROUP+i] | (p[grp*GROUP+i] & gg);
        gp = gp & p[grp*GROUP+i];
      end
      gc[grp+1] = gg | (gp & gc[grp]);
    end
    return {gc[GROUPS_PER_STAGE], s};
  endfunction

  for (genvar k = 1; k <= NS; k++) begin : stg
    localparam int LO = (k - 1) * S;

    logic [WIDTH-LO-1:0] a_up, b_up;
    logic                ci, v_in;
    logic [S:0]          r;
    logic [k*S-1:0]      s_nxt;
    logic                v_q, c_q;
    logic [k*S-1:0]      s_q;

    if (k == 1) begin : src
      assign a_up  = a;
      assign b_up  = b_eff;
      assign ci    = c0;
      assign v_in  = in_valid;
      assign s_nxt = r[S-1:0];
    end else begin : src
      assign a_up  = stg[k-1].fwd.a_q;
      assign b_up  = stg[k-1].fwd.b_q;
      assign ci    = stg[k-1].c_q;
      assign v_in  = stg[k-1].v_q;
      assign s_nxt = {r[S-1:0], stg[k-1].s_q};
    end

    assign r = cla_slice(a_up[S-1:0], b_up[S-1:0], ci);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= r[S];
        s_q <= s_nxt;
      end
    end

    // unresolved upper operand bits travel with the op
    if (k < NS) begin : fwd
      logic [WIDTH-k*S-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_up[WIDTH-LO-1:S];
          b_q <= b_up[WIDTH-LO-1:S];
        end
      end
    end

    if (k == NS) begin : fin
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (adv) begin
          ovf  <= r[S] ^ a_up[S-1] ^ b_up[S-1] ^ r[S-1];
          zero <= ~|s_nxt;
        end
      end
    end
  end

  assign out_valid = stg[NS].v_q;
  assign sum       = stg[NS].s_q;
  assign cout      = stg[NS].c_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations run side by side against an
// arithmetic reference pipeline, with directed corner cases and random traffic.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv[3], ordy[3], cin_i[3], sub_i[3];
  logic [63:0] a_i[3], b_i[3];
  logic        ir[3], ovl[3], co[3], of[3], zr[3];
  logic [63:0] sm[3];
  logic [31:0] s0;
  logic [15:0] s1;
  logic [63:0] s2;

  assign sm[0] = {32'd0, s0};
  assign sm[1] = {48'd0, s1};
  assign sm[2] = s2;

  cla_pipe_adder dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_i[0][31:0]), .b(b_i[0][31:0]), .cin(cin_i[0]), .sub(sub_i[0]),
    .out_valid(ovl[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_i[1][15:0]), .b(b_i[1][15:0]), .cin(cin_i[1]), .sub(sub_i[1]),
    .out_valid(ovl[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

  cla_pipe_adder #(.WIDTH(64), .GROUP(8), .GROUPS_PER_STAGE(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .sub(sub_i[2]),
    .out_valid(ovl[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

  int checks = 0;
  int errors = 0;

  int          nsv[3] = '{4, 1, 4};
  int          wv[3]  = '{32, 16, 64};
  logic        mv[3][4];
  logic [66:0] mr[3][4];

  // {zero, ovf, cout, sum} from plain integer arithmetic
  function automatic logic [66:0] ref_op(int w, logic [63:0] a, logic [63:0] b,
                                         logic ci, logic sb);
    logic [63:0] mask, aa, bb, s;
    logic [64:0] full;
    logic        cy, ov, sa, sbb, ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa = a & mask;
    bb = b & mask;
    if (sb) begin
      s  = (aa - bb) & mask;
      cy = (aa >= bb);
    end else begin
      full = {1'b0, aa} + {1'b0, bb} + {64'd0, ci};
      s    = full[63:0] & mask;
      cy   = full[w];
    end
    sa  = aa[w-1];
    sbb = bb[w-1];
    ss  = s[w-1];
    ov  = sb ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
    return {(s == 64'd0), ov, cy, s};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic adv[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      adv[i] = !mv[i][nsv[i]-1] || ordy[i];
      if (rst_n) chk($sformatf("in_ready%0d", i), {66'd0, ir[i]}, {66'd0, adv[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) mv[i][k] = 1'b0;
      end else if (adv[i]) begin
        for (int k = 3; k > 0; k--) begin
          mv[i][k] = mv[i][k-1];
          mr[i][k] = mr[i][k-1];
        end
        mv[i][0] = iv[i];
        mr[i][0] = ref_op(wv[i], a_i[i], b_i[i], cin_i[i], sub_i[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid%0d", i), {66'd0, ovl[i]}, {66'd0, mv[i][nsv[i]-1]});
      if (mv[i][nsv[i]-1])
        chk($sformatf("result%0d", i), {zr[i], of[i], co[i], sm[i]}, mr[i][nsv[i]-1]);
    end
  endtask

  task automatic run_one(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic sb, input logic [63:0] es,
                         input logic ec, input logic eo, input logic ez);
    for (int j = 0; j < 3; j++) ordy[j] = 1'b1;
    iv[i] = 1'b1; a_i[i] = a; b_i[i] = b; cin_i[i] = ci; sub_i[i] = sb;
    tick();
    iv[i] = 1'b0;
    for (int n = 0; n < nsv[i] - 1; n++) begin
      chk($sformatf("lat_early%0d", i), {66'd0, ovl[i]}, 67'd0);
      tick();
    end
    chk($sformatf("lat_due%0d", i), {66'd0, ovl[i]}, 67'd1);
    chk($sformatf("directed%0d", i), {zr[i], of[i], co[i], sm[i]}, {ez, eo, ec, es});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] outs[$];
    logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        acc;
    int          idx, got;

    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; ordy[i] = 1; cin_i[i] = 0; sub_i[i] = 0; a_i[i] = '0; b_i[i] = '0;
      for (int k = 0; k < 4; k++) begin mv[i][k] = 0; mr[i][k] = '0; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_flags%0d", i), {zr[i], of[i], co[i], sm[i]}, 67'd0);
    rst_n = 1'b1;

    run_one(0, 64'h5, 64'h3, 0, 0, 64'h8, 0, 0, 0);
    run_one(0, 64'hFFFF_FFFF, 64'h0, 1, 0, 64'h0, 1, 0, 1);
    run_one(0, 64'h7FFF_FFFF, 64'h1, 0, 0, 64'h8000_0000, 0, 1, 0);
    run_one(0, 64'h5, 64'h7, 0, 1, 64'hFFFF_FFFE, 0, 0, 0);
    run_one(0, 64'h5, 64'h7, 1, 1, 64'hFFFF_FFFE, 0, 0, 0);
    run_one(0, 64'h8000_0000, 64'h1, 0, 1, 64'h7FFF_FFFF, 1, 1, 0);
    run_one(1, 64'hFFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1);
    run_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1);
    run_one(2, 64'h0000_0001_0000_0000, 64'h1, 0, 1, 64'h0000_0000_FFFF_FFFF, 1, 0, 0);

    // streaming under a 1,0,0,1 out_ready pattern
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      ordy[0] = pat[cyc % 4];
      iv[0] = (idx < 8);
      a_i[0] = 64'(idx + 1); b_i[0] = 64'(idx + 1); cin_i[0] = 0; sub_i[0] = 0;
      #1;
      if (ovl[0] && ordy[0]) begin outs.push_back(sm[0]); got++; end
      acc = iv[0] && (!mv[0][3] || ordy[0]);
      tick();
      if (acc) idx++;
    end
    chk("stream_count", 67'(outs.size()), 67'd8);
    for (int j = 0; j < outs.size(); j++)
      chk($sformatf("stream_order%0d", j), {3'b0, outs[j]}, 67'(2 * (j + 1)));
    iv[0] = 0; ordy[0] = 1;
    for (int n = 0; n < 5; n++) tick();

    // reset while three ops are in flight
    for (int n = 0; n < 3; n++) begin
      iv[0] = 1; a_i[0] = 64'(100 + n); b_i[0] = 64'd1;
      tick();
    end
    iv[0] = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("flush_valid", {66'd0, ovl[0]}, 67'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("flush_quiet", {66'd0, ovl[0]}, 67'd0);
    end
    run_one(0, 64'h9, 64'h4, 0, 1, 64'h5, 1, 0, 0);

    // random traffic with random backpressure on all three instances
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        ordy[i]  = ($urandom_range(0, 3) != 0);
        iv[i]    = $urandom_range(0, 1);
        a_i[i]   = {$urandom, $urandom};
        b_i[i]   = ($urandom_range(0, 7) == 0) ? ~a_i[i] : {$urandom, $urandom};
        cin_i[i] = $urandom_range(0, 1);
        sub_i[i] = $urandom_range(0, 1);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin iv[i] = 0; ordy[i] = 1; end
    for (int n = 0; n < 6; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
